intersection_scheduler: RTL and testbench
=========================================

Name: intersection_scheduler

Overview:
- Sequences the right-of-way for a two-road intersection (main road, side road) plus a pedestrian crossing phase.
- Drives one-hot light codes for each road and a walk signal.
- Main road holds green by default. The side road and the pedestrian crossing are served on demand, under min/max green timing and an all-red clearance interval between phases.
- Sits above the per-signal light heads and is the single arbiter of which approach owns the junction.

Parameters:
- GREEN_MIN, 4, minimum cycles any green phase is held (1..255)
- GREEN_MAX, 8, maximum cycles SIDE_GO is held (GREEN_MIN..255)
- YELLOW_TIME, 2, cycles in each yellow phase (1..255)
- ALLRED_TIME, 1, cycles in the all-red clearance phase (1..255)
- WALK_TIME, 3, cycles the walk signal is asserted (1..255)

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- car_sensor_side  input  1  side-road vehicle present (level)
- car_sensor_main  input  1  main-road vehicle present (level; status only, does not affect sequencing)
- pedestrian_button  input  1  crossing request (level or pulse, sampled each cycle)
- lights_main  output  3  main-road light: RED=3'b001, YELLOW=3'b010, GREEN=3'b100
- lights_side  output  3  side-road light, same encoding
- walk  output  1  pedestrian walk indication
- ped_pending  output  1  latched, not-yet-served pedestrian request
- phase  output  3  current state encoding, for debug

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (reset_n). All state is in flops cleared by reset_n low.
- Reset values:
  - state=MAIN_GO, timer=0, next_road=SIDE, ped_pending=0
  - lights_main=GREEN, lights_side=RED, walk=0, phase=0
- Outputs are Moore: decoded from registered state only, so there is no combinational path from inputs to outputs.
- States and encoding: MAIN_GO=0, MAIN_WARN=1, CLEAR=2, SIDE_GO=3, SIDE_WARN=4, PED_WALK=5. Codes 6 and 7 are illegal and go to CLEAR on the next clock.
- Timer:
  - 8-bit; equals 0 on the first cycle of every state.
  - Increments each cycle while the state is unchanged and saturates at 255.
  - A state lasting N cycles exits when timer==N-1.
- MAIN_GO: main=GREEN, side=RED. Exits to MAIN_WARN when timer>=GREEN_MIN-1 and (car_sensor_side or ped_pending). With no demand it stays indefinitely. There is no max limit on main green.
- MAIN_WARN: main=YELLOW, side=RED. Exits to CLEAR at timer==YELLOW_TIME-1. Sets next_road=SIDE on exit.
- SIDE_GO: main=RED, side=GREEN. Exits to SIDE_WARN on the first cycle where any of these holds:
  - timer==GREEN_MAX-1
  - timer>=GREEN_MIN-1 and !car_sensor_side
  - timer>=GREEN_MIN-1 and ped_pending
- SIDE_WARN: main=RED, side=YELLOW. Exits to CLEAR at timer==YELLOW_TIME-1. Sets next_road=MAIN on exit.
- CLEAR: both RED. At timer==ALLRED_TIME-1 the exit target is chosen by priority:
  - ped_pending -> PED_WALK
  - else next_road==SIDE and car_sensor_side -> SIDE_GO
  - else -> MAIN_GO
- PED_WALK: both RED, walk=1. Exits to CLEAR at timer==WALK_TIME-1. next_road is unchanged, so the interrupted rotation resumes afterwards.
- ped_pending:
  - Set on any cycle pedestrian_button=1 while state!=PED_WALK.
  - Cleared on the CLEAR->PED_WALK transition edge. If set and clear occur on the same edge, clear wins.
  - A button press during PED_WALK is ignored.
- Safety invariant: at most one of lights_main/lights_side is non-RED in any cycle, and walk=1 implies both are RED.
- Reset mid-phase: asserting reset_n low immediately forces the reset values, regardless of state or timer.

Test Plan:
- Reset with all inputs 0, run 50 cycles -> phase=0, main=GREEN, side=RED, walk=0 throughout.
- Reset released, car_sensor_side held 1 -> the following occupancies, then repeat:
  - MAIN_GO 4 cycles, MAIN_WARN 2, CLEAR 1
  - SIDE_GO 8 cycles (GREEN_MAX), SIDE_WARN 2, CLEAR 1
  - back to MAIN_GO for 4 cycles
- car_sensor_side pulsed 1 for 1 cycle at cycle 10 -> MAIN_WARN entered once MAIN_GO has been held ≥4 cycles. SIDE_GO is not entered, because the sensor is low at the CLEAR exit, so flow returns to MAIN_GO.
- car_sensor_side=1 held, pedestrian_button pulsed 1 cycle during SIDE_GO timer=1 -> ped_pending=1 next cycle. SIDE_GO exits at timer=3, followed by SIDE_WARN 2, CLEAR 1, PED_WALK 3 with walk=1 and ped_pending=0. Then CLEAR 1, then MAIN_GO (next_road=MAIN).
- pedestrian_button held 1 through PED_WALK -> ped_pending stays 0 during the walk, becomes 1 the cycle after exit, and triggers a second walk after the following CLEAR.
- reset_n asserted low during SIDE_GO timer=5 -> outputs return to main=GREEN, side=RED, walk=0, ped_pending=0 without waiting for a clock edge.
- Assertion over all tests: never both lights non-RED; walk=1 only with both RED.

Source files
------------

// File: rtl/intersection_scheduler.sv
// Right-of-way sequencer for a main/side road junction with a pedestrian
// crossing phase. Main road rests on green; side road and walk on demand.
// Ports:
//   clk, reset_n          clock (rising edge), async active-low reset
//   car_sensor_side       side-road vehicle present (level)
//   car_sensor_main       main-road vehicle present (status only)
//   pedestrian_button     crossing request, sampled every cycle
//   lights_main/side      one-hot light codes RED=001 YELLOW=010 GREEN=100
//   walk                  pedestrian walk indication
//   ped_pending           latched, not-yet-served crossing request
//   phase                 current state code, for debug
module intersection_scheduler #(
    parameter int unsigned GREEN_MIN   = 4,
    parameter int unsigned GREEN_MAX   = 8,
    parameter int unsigned YELLOW_TIME = 2,
    parameter int unsigned ALLRED_TIME = 1,
    parameter int unsigned WALK_TIME   = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       car_sensor_side,
    input  logic       car_sensor_main,
    input  logic       pedestrian_button,
    output logic [2:0] lights_main,
    output logic [2:0] lights_side,
    output logic       walk,
    output logic       ped_pending,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        MAIN_GO   = 3'd0,
        MAIN_WARN = 3'd1,
        CLEAR     = 3'd2,
        SIDE_GO   = 3'd3,
        SIDE_WARN = 3'd4,
        PED_WALK  = 3'd5
    } state_t;

    typedef enum logic {
        ROAD_MAIN = 1'b0,
        ROAD_SIDE = 1'b1
    } road_t;

    localparam logic [2:0] RED    = 3'b001;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b100;

    // Timer values on the last cycle of each timed interval
    localparam logic [7:0] GMIN_END = 8'(GREEN_MIN - 1);
    localparam logic [7:0] GMAX_END = 8'(GREEN_MAX - 1);
    localparam logic [7:0] YEL_END  = 8'(YELLOW_TIME - 1);
    localparam logic [7:0] AR_END   = 8'(ALLRED_TIME - 1);
    localparam logic [7:0] WALK_END = 8'(WALK_TIME - 1);

    state_t     state;
    state_t     state_n;
    road_t      next_road;
    road_t      next_road_n;
    logic [7:0] timer;
    logic       ped_clear;
    logic       green_min_met;

    // Main-road presence is reported upstream but never alters sequencing
    logic unused_main_sensor;
    assign unused_main_sensor = car_sensor_main;

    assign green_min_met = (timer >= GMIN_END);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= MAIN_GO;
            timer     <= 8'd0;
            next_road <= ROAD_SIDE;
        end else begin
            state     <= state_n;
            next_road <= next_road_n;
            if (state_n != state) begin
                timer <= 8'd0;
            end else if (timer != 8'hFF) begin
                timer <= timer + 8'd1;
            end
        end
    end

    // Serving the walk clears the request even if the button is still held
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ped_pending <= 1'b0;
        end else if (ped_clear) begin
            ped_pending <= 1'b0;
        end else if (pedestrian_button && state != PED_WALK) begin
            ped_pending <= 1'b1;
        end
    end

    always_comb begin
        state_n     = state;
        next_road_n = next_road;
        ped_clear   = 1'b0;
        unique case (state)
            MAIN_GO: begin
                if (green_min_met && (car_sensor_side || ped_pending)) begin
                    state_n = MAIN_WARN;
                end
            end
            MAIN_WARN: begin
                if (timer == YEL_END) begin
                    state_n     = CLEAR;
                    next_road_n = ROAD_SIDE;
                end
            end
            SIDE_GO: begin
                if (timer == GMAX_END ||
                    (green_min_met && (!car_sensor_side || ped_pending))) begin
                    state_n = SIDE_WARN;
                end
            end
            SIDE_WARN: begin
                if (timer == YEL_END) begin
                    state_n     = CLEAR;
                    next_road_n = ROAD_MAIN;
                end
            end
            CLEAR: begin
                if (timer == AR_END) begin
                    if (ped_pending) begin
                        state_n   = PED_WALK;
                        ped_clear = 1'b1;
                    end else if (next_road == ROAD_SIDE && car_sensor_side) begin
                        state_n = SIDE_GO;
                    end else begin
                        state_n = MAIN_GO;
                    end
                end
            end
            PED_WALK: begin
                if (timer == WALK_END) begin
                    state_n = CLEAR;
                end
            end
            default: begin
                state_n = CLEAR;
            end
        endcase
    end

    // Any code not listed shows both roads red
    always_comb begin
        lights_main = RED;
        lights_side = RED;
        walk        = 1'b0;
        unique case (state)
            MAIN_GO:   lights_main = GREEN;
            MAIN_WARN: lights_main = YELLOW;
            SIDE_GO:   lights_side = GREEN;
            SIDE_WARN: lights_side = YELLOW;
            PED_WALK:  walk        = 1'b1;
            default: begin
                lights_main = RED;
                lights_side = RED;
            end
        endcase
    end

    assign phase = state;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Self-checking bench for intersection_scheduler: a phase/occupancy model
// checked every cycle plus directed sequences with literal expectations.
module tb_intersection_scheduler;

    localparam int GREEN_MIN   = 4;
    localparam int GREEN_MAX   = 8;
    localparam int YELLOW_TIME = 2;
    localparam int ALLRED_TIME = 1;
    localparam int WALK_TIME   = 3;

    localparam int P_MGO   = 0;
    localparam int P_MWARN = 1;
    localparam int P_CLEAR = 2;
    localparam int P_SGO   = 3;
    localparam int P_SWARN = 4;
    localparam int P_WALK  = 5;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       car_sensor_side = 1'b0;
    logic       car_sensor_main = 1'b0;
    logic       pedestrian_button = 1'b0;
    logic [2:0] lights_main;
    logic [2:0] lights_side;
    logic       walk;
    logic       ped_pending;
    logic [2:0] phase;

    int checks = 0;
    int failures = 0;

    intersection_scheduler #(
        .GREEN_MIN  (GREEN_MIN),
        .GREEN_MAX  (GREEN_MAX),
        .YELLOW_TIME(YELLOW_TIME),
        .ALLRED_TIME(ALLRED_TIME),
        .WALK_TIME  (WALK_TIME)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .car_sensor_side  (car_sensor_side),
        .car_sensor_main  (car_sensor_main),
        .pedestrian_button(pedestrian_button),
        .lights_main      (lights_main),
        .lights_side      (lights_side),
        .walk             (walk),
        .ped_pending      (ped_pending),
        .phase            (phase)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks which approach owns the junction and how many cycles it has
    // held it; held = m_age + 1 on the cycle being decided.
    int m_ph;
    int m_age;
    bit m_side_next;
    bit m_ped;

    function automatic int decide(input int ph, input int age,
                                  input bit side, input bit ped,
                                  input bit side_next);
        int held;
        held = age + 1;
        case (ph)
            P_MGO:   return (held >= GREEN_MIN && (side || ped)) ? P_MWARN : P_MGO;
            P_MWARN: return (held == YELLOW_TIME) ? P_CLEAR : P_MWARN;
            P_SGO: begin
                if (held == GREEN_MAX) return P_SWARN;
                if (held >= GREEN_MIN && (!side || ped)) return P_SWARN;
                return P_SGO;
            end
            P_SWARN: return (held == YELLOW_TIME) ? P_CLEAR : P_SWARN;
            P_CLEAR: begin
                if (held != ALLRED_TIME) return P_CLEAR;
                if (ped) return P_WALK;
                if (side_next && side) return P_SGO;
                return P_MGO;
            end
            P_WALK:  return (held == WALK_TIME) ? P_CLEAR : P_WALK;
            default: return P_CLEAR;
        endcase
    endfunction

    function automatic logic [2:0] main_light(input int ph);
        case (ph)
            P_MGO:   return 3'b100;
            P_MWARN: return 3'b010;
            default: return 3'b001;
        endcase
    endfunction

    function automatic logic [2:0] side_light(input int ph);
        case (ph)
            P_SGO:   return 3'b100;
            P_SWARN: return 3'b010;
            default: return 3'b001;
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_ph        <= P_MGO;
            m_age       <= 0;
            m_side_next <= 1'b1;
            m_ped       <= 1'b0;
        end else begin
            m_ph  <= decide(m_ph, m_age, car_sensor_side, m_ped, m_side_next);
            m_age <= (decide(m_ph, m_age, car_sensor_side, m_ped, m_side_next) != m_ph)
                     ? 0 : m_age + 1;
            if (m_ph == P_MWARN && m_age + 1 == YELLOW_TIME) m_side_next <= 1'b1;
            if (m_ph == P_SWARN && m_age + 1 == YELLOW_TIME) m_side_next <= 1'b0;
            if (m_ph == P_CLEAR && m_age + 1 == ALLRED_TIME && m_ped)
                m_ped <= 1'b0;
            else if (pedestrian_button && m_ph != P_WALK)
                m_ped <= 1'b1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (reset_n) begin
            check("phase", int'(phase), m_ph);
            check("lights_main", int'(lights_main), int'(main_light(m_ph)));
            check("lights_side", int'(lights_side), int'(side_light(m_ph)));
            check("walk", int'(walk), int'(m_ph == P_WALK));
            check("ped_pending", int'(ped_pending), int'(m_ped));
            check("safety", int'((lights_main != 3'b001 && lights_side != 3'b001) ||
                                 (walk && (lights_main != 3'b001 || lights_side != 3'b001))), 0);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic do_reset();
        reset_n           = 1'b0;
        car_sensor_side   = 1'b0;
        car_sensor_main   = 1'b0;
        pedestrian_button = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    int seq2 [22] = '{0,0,0,0,1,1,2,3,3,3,3,3,3,3,3,4,4,2,0,0,0,0};

    initial begin
        // Idle: main road holds green indefinitely
        do_reset();
        for (int i = 0; i < 50; i++) begin
            check("idle_phase", int'(phase), 0);
            check("idle_main", int'(lights_main), 4);
            @(negedge clk);
        end

        // Side demand held: full rotation with side green at its max
        do_reset();
        car_sensor_side = 1'b1;
        for (int i = 0; i < 22; i++) begin
            check($sformatf("rot_phase[%0d]", i), int'(phase), seq2[i]);
            @(negedge clk);
        end

        // One-cycle side pulse: warn and clear, side never served
        do_reset();
        for (int i = 0; i < 20; i++) begin
            car_sensor_side = (i == 10);
            if (i == 11) check("pulse_warn", int'(phase), 1);
            if (i == 13) check("pulse_clear", int'(phase), 2);
            if (i == 14) check("pulse_back", int'(phase), 0);
            @(negedge clk);
        end
        car_sensor_side = 1'b0;

        // Pedestrian press during side green cuts it short
        do_reset();
        car_sensor_side = 1'b1;
        for (int i = 0; i < 22; i++) begin
            pedestrian_button = (i == 8);
            if (i == 8)  check("ped_sgo_t1", int'(phase), 3);
            if (i == 9)  check("ped_latched", int'(ped_pending), 1);
            if (i == 10) check("ped_sgo_last", int'(phase), 3);
            if (i == 11) check("ped_swarn", int'(phase), 4);
            if (i == 14 || i == 16) check("ped_walk", int'(walk), 1);
            if (i == 14) check("ped_served", int'(ped_pending), 0);
            if (i == 17) check("ped_clear2", int'(phase), 2);
            if (i == 18) check("ped_resume_main", int'(phase), 0);
            @(negedge clk);
        end
        pedestrian_button = 1'b0;

        // Button held through the walk: re-latched only after it ends
        do_reset();
        for (int i = 0; i < 26; i++) begin
            pedestrian_button = (i == 5) || (i >= 10 && i <= 13);
            if (i == 10) check("hold_walk", int'(phase), 5);
            if (i == 12) check("hold_no_latch", int'(ped_pending), 0);
            if (i == 14) check("hold_relatch", int'(ped_pending), 1);
            if (i == 14) check("hold_main", int'(phase), 0);
            if (i == 21) check("hold_walk2", int'(phase), 5);
            @(negedge clk);
        end
        pedestrian_button = 1'b0;

        // Reset asserted mid side green takes effect without a clock
        do_reset();
        car_sensor_side = 1'b1;
        repeat (12) @(negedge clk);
        check("rst_pre_sgo", int'(phase), 3);
        #2 reset_n = 1'b0;
        #1;
        check("rst_main", int'(lights_main), 4);
        check("rst_side", int'(lights_side), 1);
        check("rst_walk", int'(walk), 0);
        check("rst_ped", int'(ped_pending), 0);
        check("rst_phase", int'(phase), 0);
        @(negedge clk);
        car_sensor_side = 1'b0;
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
